spi_slave_burst: RTL and testbench

Parametrised successor to the single-byte SPI slave. It has the following capabilities:
- Configurable word width and bit order.
- Back-to-back multi-word bursts within one cs-low window.
- An RX FIFO and a TX holding register, each with valid/ready handshakes toward local logic.
- Sticky error status.

It sits between the external SPI master pins and local logic, entirely in the sclk domain.

---
 rtl/spi_slave_burst_if.sv | 49 ++++
 rtl/spi_slave_burst.sv | 168 ++++++++++++++++
 tb/tb_spi_slave_burst.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_burst_if.sv
// Local-side and pin-side signals of spi_slave_burst, grouped for port connection.
// parity_err is present only when SPI_PARITY_EN is defined.
interface spi_slave_burst_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) ();
   localparam int LW = $clog2(DEPTH) + 1;

   logic                  cs;
   logic                  mosi;
   logic                  miso;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [LW-1:0]         rx_level;
   logic                  clear_status;
   logic                  rx_overflow;
   logic                  tx_underrun;
   logic                  frame_abort;

`ifdef SPI_PARITY_EN
   logic                  parity_err;

   modport slave (
      input  cs, mosi, tx_data, tx_valid, rx_ready, clear_status,
      output miso, tx_ready, rx_data, rx_valid, rx_level,
             rx_overflow, tx_underrun, frame_abort, parity_err
   );
   modport master (
      output cs, mosi, tx_data, tx_valid, rx_ready, clear_status,
      input  miso, tx_ready, rx_data, rx_valid, rx_level,
             rx_overflow, tx_underrun, frame_abort, parity_err
   );
`else
   modport slave (
      input  cs, mosi, tx_data, tx_valid, rx_ready, clear_status,
      output miso, tx_ready, rx_data, rx_valid, rx_level,
             rx_overflow, tx_underrun, frame_abort
   );
   modport master (
      output cs, mosi, tx_data, tx_valid, rx_ready, clear_status,
      input  miso, tx_ready, rx_data, rx_valid, rx_level,
             rx_overflow, tx_underrun, frame_abort
   );
`endif
endinterface

// File: rtl/spi_slave_burst.sv
// Burst-capable SPI slave in the sclk domain: RX FIFO, TX holding register, sticky status.
// Define SPI_PARITY_EN to append an even-parity bit to every frame and expose parity_err.
module spi_slave_burst #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int LSB_FIRST  = 0
) (
   input logic              sclk,
   input logic              reset,
   spi_slave_burst_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
`ifdef SPI_PARITY_EN
   localparam int FRAME = DATA_WIDTH + 1;
`else
   localparam int FRAME = DATA_WIDTH;
`endif
   localparam int CW = $clog2(FRAME);
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                  ovf_q, ovf_d, und_q, und_d, abort_q, abort_d;

   logic [DATA_WIDTH-1:0] rx_next, rx_word;
   logic                  bit0, last, empty, full, push, pop, accept, data_bit;
   logic                  und_set, abort_set, first_bit, out_bit, miso_o;

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
      return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
   endfunction

   assign bit0    = (bit_cnt_q == '0);
   assign last    = (bit_cnt_q == LAST);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rx_next = (LSB_FIRST != 0) ? {bus.mosi, rx_shift_q[DATA_WIDTH-1:1]}
                                     : {rx_shift_q[DATA_WIDTH-2:0], bus.mosi};
   assign push    = ~bus.cs & last;
   assign pop     = ~empty & bus.rx_ready;
   assign accept  = push & (~full | pop);

`ifdef SPI_PARITY_EN
   logic tx_par_q, tx_par_d, par_q, par_d, par_fail;

   // The parity bit is not shifted in, so the data word is already complete in rx_shift_q.
   assign rx_word  = rx_shift_q;
   assign data_bit = ~last;
   assign par_fail = ^{rx_shift_q, bus.mosi};
   assign tx_par_d = (~bus.cs & bit0) ? (hold_valid_q & ^hold_q) : tx_par_q;
   assign par_d    = (push & par_fail) | (par_q & ~bus.clear_status);
   assign bus.parity_err = par_q;

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         tx_par_q <= 1'b0;
         par_q    <= 1'b0;
      end else begin
         tx_par_q <= tx_par_d;
         par_q    <= par_d;
      end
   end
`else
   assign rx_word  = rx_next;
   assign data_bit = 1'b1;
`endif

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      rx_shift_d   = rx_shift_q;
      tx_shift_d   = tx_shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      und_set      = 1'b0;
      abort_set    = 1'b0;
      if (bus.cs) begin
         bit_cnt_d  = '0;
         rx_shift_d = '0;
         abort_set  = ~bit0;
      end else begin
         bit_cnt_d = last ? '0 : bit_cnt_q + 1'b1;
         if (data_bit) rx_shift_d = rx_next;
         if (bit0) begin
            tx_shift_d   = hold_valid_q ? shift_out(hold_q) : '0;
            hold_valid_d = 1'b0;
            und_set      = ~hold_valid_q;
         end else begin
            tx_shift_d = shift_out(tx_shift_q);
         end
      end
      // tx_ready is ~hold_valid_q, so a load never collides with a bit-0 consume.
      if (bus.tx_valid && !hold_valid_q) begin
         hold_d       = bus.tx_data;
         hold_valid_d = 1'b1;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (accept) begin
         mem_d[wr_ptr_q[AW-1:0]] = rx_word;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_comb begin
      ovf_d   = (push & ~accept) | (ovf_q & ~bus.clear_status);
      und_d   = und_set | (und_q & ~bus.clear_status);
      abort_d = abort_set | (abort_q & ~bus.clear_status);
   end

   always_comb begin
      first_bit = (LSB_FIRST != 0) ? hold_q[0] : hold_q[DATA_WIDTH-1];
      out_bit   = (LSB_FIRST != 0) ? tx_shift_q[0] : tx_shift_q[DATA_WIDTH-1];
      if (bus.cs)    miso_o = 1'b0;
      else if (bit0) miso_o = hold_valid_q & first_bit;
`ifdef SPI_PARITY_EN
      else if (last) miso_o = tx_par_q;
`endif
      else           miso_o = out_bit;
   end

   assign bus.miso        = miso_o;
   assign bus.tx_ready    = ~hold_valid_q;
   assign bus.rx_data     = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.rx_valid    = ~empty;
   assign bus.rx_level    = wr_ptr_q - rd_ptr_q;
   assign bus.rx_overflow = ovf_q;
   assign bus.tx_underrun = und_q;
   assign bus.frame_abort = abort_q;

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         bit_cnt_q    <= '0;
         rx_shift_q   <= '0;
         tx_shift_q   <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovf_q        <= 1'b0;
         und_q        <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         rx_shift_q   <= rx_shift_d;
         tx_shift_q   <= tx_shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ovf_q        <= ovf_d;
         und_q        <= und_d;
         abort_q      <= abort_d;
      end
   end
endmodule

// File: tb/tb_spi_slave_burst.sv
// MSB-first and LSB-first instances share one serial stream and local stimulus; expected
// words are derived from the bit stream and a word-level model of holding register and FIFO.
module tb_spi_slave_burst;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
`ifdef SPI_PARITY_EN
   localparam int FW = DW + 1;
`else
   localparam int FW = DW;
`endif
   localparam bit PAR = (FW != DW);

   logic          sclk = 1'b0;
   logic          reset;
   logic          cs, mosi, tx_valid, rx_ready, clear_status;
   logic [DW-1:0] tx_data;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0] rxq_m[$], rxq_l[$];
   logic [FW-1:0] misoq_m[$], misoq_l[$];
   bit            hold_full;
   logic [DW-1:0] hold_val;
   bit            e_ovf, e_und, e_abort, e_par, partial;

   spi_slave_burst_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifm ();
   spi_slave_burst_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifl ();

   assign ifm.cs = cs;             assign ifl.cs = cs;
   assign ifm.mosi = mosi;         assign ifl.mosi = mosi;
   assign ifm.tx_data = tx_data;   assign ifl.tx_data = tx_data;
   assign ifm.tx_valid = tx_valid; assign ifl.tx_valid = tx_valid;
   assign ifm.rx_ready = rx_ready; assign ifl.rx_ready = rx_ready;
   assign ifm.clear_status = clear_status;
   assign ifl.clear_status = clear_status;

   spi_slave_burst #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LSB_FIRST(0)) dut_m (
      .sclk(sclk), .reset(reset), .bus(ifm));
   spi_slave_burst #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LSB_FIRST(1)) dut_l (
      .sclk(sclk), .reset(reset), .bus(ifl));

   always #5 sclk = ~sclk;

   function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
      return r;
   endfunction

   // Serial frame as seen on the wire, first bit in the MSB; parity is kept only when enabled.
   function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] v, input logic p);
      logic [DW:0] t;
      t = {v, p};
      return t[DW -: FW];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge sclk);
      #2;
   endtask

   // A missing expectation is forced to mismatch by comparing against the inverted actual.
   always @(negedge sclk) begin
      if (reset && ifm.rx_valid && rx_ready)
         chk("rx_data_msb", ifm.rx_data, (rxq_m.size() > 0) ? rxq_m.pop_front() : ~ifm.rx_data);
      if (reset && ifl.rx_valid && rx_ready)
         chk("rx_data_lsb", ifl.rx_data, (rxq_l.size() > 0) ? rxq_l.pop_front() : ~ifl.rx_data);
   end

   int            mc_m = 0, mc_l = 0;
   logic [FW-1:0] ma_m, ma_l;
   always @(negedge sclk) begin
      if (!reset) begin
         mc_m = 0;
         mc_l = 0;
      end else if (cs) begin
         if (mc_m != 0 && misoq_m.size() > 0) misoq_m.delete(0);
         if (mc_l != 0 && misoq_l.size() > 0) misoq_l.delete(0);
         mc_m = 0;
         mc_l = 0;
      end else begin
         ma_m = {ma_m[FW-2:0], ifm.miso};
         ma_l = {ma_l[FW-2:0], ifl.miso};
         mc_m++;
         mc_l++;
         if (mc_m == FW) begin
            chk("miso_frame_msb", ma_m, (misoq_m.size() > 0) ? misoq_m.pop_front() : ~ma_m);
            mc_m = 0;
         end
         if (mc_l == FW) begin
            chk("miso_frame_lsb", ma_l, (misoq_l.size() > 0) ? misoq_l.pop_front() : ~ma_l);
            mc_l = 0;
         end
      end
   end

   task automatic check_status(input string tag);
      chk({tag, "_level_msb"}, ifm.rx_level, rxq_m.size());
      chk({tag, "_level_lsb"}, ifl.rx_level, rxq_l.size());
      chk({tag, "_tx_ready"}, {ifm.tx_ready, ifl.tx_ready}, {2{!hold_full}});
      chk({tag, "_rx_overflow"}, {ifm.rx_overflow, ifl.rx_overflow}, {2{e_ovf}});
      chk({tag, "_tx_underrun"}, {ifm.tx_underrun, ifl.tx_underrun}, {2{e_und}});
      chk({tag, "_frame_abort"}, {ifm.frame_abort, ifl.frame_abort}, {2{e_abort}});
`ifdef SPI_PARITY_EN
      chk({tag, "_parity_err"}, {ifm.parity_err, ifl.parity_err}, {2{e_par}});
`endif
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rx_valid"}, {ifm.rx_valid, ifl.rx_valid}, 0);
      chk({tag, "_rx_level"}, {ifm.rx_level, ifl.rx_level}, 0);
      chk({tag, "_rx_data"}, {ifm.rx_data, ifl.rx_data}, 0);
      chk({tag, "_tx_ready"}, {ifm.tx_ready, ifl.tx_ready}, 2'b11);
      chk({tag, "_miso"}, {ifm.miso, ifl.miso}, 0);
      chk({tag, "_flags"}, {ifm.rx_overflow, ifm.tx_underrun, ifm.frame_abort,
                            ifl.rx_overflow, ifl.tx_underrun, ifl.frame_abort}, 0);
`ifdef SPI_PARITY_EN
      chk({tag, "_parity_err"}, {ifm.parity_err, ifl.parity_err}, 0);
`endif
   endtask

   task automatic load(input logic [DW-1:0] v);
      chk("load_tx_ready", {ifm.tx_ready, ifl.tx_ready}, {2{!hold_full}});
      tx_valid = 1'b1;
      tx_data  = v;
      step();
      tx_valid  = 1'b0;
      hold_full = 1'b1;
      hold_val  = v;
   endtask

   // rdy: 0 = rx_ready low, 1 = random per edge, 2 = high only on the last bit edge.
   task automatic send_word(input logic [DW-1:0] w, input int nbits, input bit bad_par,
                            input bit refill, input int rpos, input logic [DW-1:0] rv,
                            input int rdy);
      logic [FW-1:0] fr;
      logic [DW-1:0] h;
      bit            was_full, pop_now;
      fr       = frame_of(w, (^w) ^ bad_par);
      was_full = hold_full;
      h        = hold_full ? hold_val : '0;
      if (!hold_full) e_und = 1'b1;
      hold_full = 1'b0;
      misoq_m.push_back(frame_of(h, ^h));
      misoq_l.push_back(frame_of(rev(h), ^h));
      for (int i = 0; i < nbits; i++) begin
         cs       = 1'b0;
         mosi     = fr[FW-1-i];
         tx_valid = refill && (i == rpos);
         tx_data  = rv;
         if (tx_valid && (i != 0 || !was_full)) begin
            hold_full = 1'b1;
            hold_val  = rv;
         end
         rx_ready = (rdy == 1) ? 1'($urandom_range(0, 1)) : (rdy == 2 && i == FW-1);
         if (i == FW-1) begin
            pop_now = rx_ready && (rxq_m.size() > 0);
            if (rxq_m.size() < DEPTH || pop_now) begin
               rxq_m.push_back(w);
               rxq_l.push_back(rev(w));
            end else begin
               e_ovf = 1'b1;
            end
            if (bad_par) e_par = 1'b1;
         end
         step();
      end
      tx_valid = 1'b0;
      partial  = (nbits < FW);
   endtask

   task automatic idle(input int n);
      cs       = 1'b1;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      if (partial) e_abort = 1'b1;
      partial = 1'b0;
      repeat (n) step();
   endtask

   task automatic clear();
      cs           = 1'b1;
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      {e_ovf, e_und, e_abort, e_par} = '0;
   endtask

   task automatic drain();
      int n;
      n  = 0;
      cs = 1'b1;
      rx_ready = 1'b1;
      while (rxq_m.size() > 0 && n < 4*DEPTH) begin
         step();
         n++;
      end
      rx_ready = 1'b0;
      chk("drain_level", {ifm.rx_level, ifl.rx_level}, 0);
      chk("drain_leftover", rxq_m.size() + rxq_l.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      reset = 1'b0; cs = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      rx_ready = 1'b0; clear_status = 1'b0;
      hold_full = 1'b0; hold_val = '0;
      {e_ovf, e_und, e_abort, e_par, partial} = '0;
      #12;
      check_reset("reset");
      reset = 1'b1;
      step();
      step();

      // single word
      load(8'h33);
      send_word(8'hCC, FW, 1'b0, 1'b0, 0, '0, 0);
      chk("single_rx_valid", {ifm.rx_valid, ifl.rx_valid}, 2'b11);
      idle(1);
      check_status("single");
      drain();

      // three-word burst with refills
      load(8'h11);
      send_word(8'hA5, FW, 1'b0, 1'b1, 2, 8'h22, 0);
      send_word(8'h3C, FW, 1'b0, 1'b1, 2, 8'h33, 0);
      send_word(8'hF0, FW, 1'b0, 1'b0, 0, '0, 0);
      idle(1);
      check_status("burst");
      drain();

      // overflow, then full FIFO with push and pop on one edge
      for (int i = 0; i < 5; i++) send_word(DW'($urandom), FW, 1'b0, 1'b0, 0, '0, 0);
      idle(1);
      check_status("overflow");
      send_word(DW'($urandom), FW, 1'b0, 1'b0, 0, '0, 2);
      idle(1);
      check_status("full_push_pop");
      drain();
      clear();
      check_status("clear_ovf");

      // underrun
      send_word(DW'($urandom), FW, 1'b0, 1'b0, 0, '0, 0);
      idle(1);
      check_status("underrun");
      clear();
      check_status("clear_und");
      drain();

      // abort after three bits, then a clean word
      load(8'h5A);
      send_word(8'h96, 3, 1'b0, 1'b0, 0, '0, 0);
      idle(1);
      check_status("abort");
      load(8'hC3);
      send_word(8'h69, FW, 1'b0, 1'b0, 0, '0, 0);
      idle(1);
      check_status("after_abort");
      drain();
      clear();

      // asynchronous reset mid-word
      load(8'hE7);
      send_word(8'h81, 3, 1'b0, 1'b0, 0, '0, 0);
      reset = 1'b0;
      #1;
      check_reset("mid_reset");
      rxq_m.delete(); rxq_l.delete(); misoq_m.delete(); misoq_l.delete();
      hold_full = 1'b0;
      {e_ovf, e_und, e_abort, e_par, partial} = '0;
      cs = 1'b1;
      step();
      reset = 1'b1;
      step();

`ifdef SPI_PARITY_EN
      load(8'h07);
      send_word(8'h01, FW, 1'b1, 1'b0, 0, '0, 0);
      idle(1);
      check_status("bad_parity");
      drain();
      clear();
`endif

      // randomized traffic
      repeat (80) begin
         nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, FW-1)) : FW;
         send_word(DW'($urandom), nb, PAR && ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 0 : 2,
                   DW'($urandom), 1);
         if (partial || $urandom_range(0, 3) == 0) begin
            idle(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) clear();
         end
      end
      idle(2);
      check_status("random");
      drain();
      check_status("final");
      chk("miso_leftover", misoq_m.size() + misoq_l.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
